ram_arbiter: RTL and testbench

Two-port arbiter that shares the single data RAM between the core's load/store port (port 0) and a secondary master such as a debug loader or DMA (port 1). Port 0 has fixed priority. A wait counter guarantees port 1 is served within a bounded number of cycles. The block sits between the requesters and the RAM, drives the RAM's `r`/`w`/`addr`/`in` pins, and routes the RAM's `out` back to the requester that issued the read.

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/arb_wait_counter.sv | 40 ++++
 rtl/ram_arbiter.sv | 102 ++++++++++
 tb/tb_ram_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types, default widths and helpers for the two-port data-RAM arbiter.
package ram_arb_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_STRB_W   = DEF_DATA_W / 8;
    localparam int DEF_MAX_WAIT = 4;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_AUX  = 1'b1
    } port_id_t;

    // An all-zero byte strobe marks the access as a read.
    function automatic logic is_read(input logic [DEF_STRB_W-1:0] we);
        return (we == '0);
    endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive arbitrations lost by the auxiliary port.
module arb_wait_counter
    import ram_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sat_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_W'(MAX_WAIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = (cnt_q == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/ram_arbiter.sv
// Fixed-priority arbiter sharing one data RAM between the core (port 0) and an
// auxiliary master (port 1), with bounded wait for port 1 and 1-cycle read return.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_W/8-1:0]   we0,
    input  logic [DATA_W/8-1:0]   we1,
    input  logic [ADDR_W-1:0]     addr0,
    input  logic [ADDR_W-1:0]     addr1,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic [DATA_W-1:0]     wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_W-1:0]     rdata0,
    output logic [DATA_W-1:0]     rdata1,
    output logic                  ram_r,
    output logic [DATA_W/8-1:0]   ram_w,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic             wait_sat;
    logic [CNT_W-1:0] wait_cnt;
    logic             rpend_q, rpend_d;
    port_id_t         rsel_q,  rsel_d;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_wait_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (req1 && !gnt1),
        .clr_i (gnt1),
        .cnt_o (wait_cnt),
        .sat_o (wait_sat)
    );

    // NOTE: every output gets a default before the branches, so no latch can be inferred.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        ram_r     = 1'b0;
        ram_w     = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        // The grant path is gated by rst_n so the RAM sees nothing while in reset.
        if (rst_n) begin
            if (req1 && (!req0 || wait_sat)) begin
                gnt1      = 1'b1;
                ram_w     = we1;
                ram_r     = is_read(we1);
                ram_addr  = addr1;
                ram_wdata = wdata1;
            end else if (req0) begin
                gnt0      = 1'b1;
                ram_w     = we0;
                ram_r     = is_read(we0);
                ram_addr  = addr0;
                ram_wdata = wdata0;
            end
        end
    end

    always_comb begin
        rpend_d = ram_r;
        rsel_d  = rsel_q;
        if (ram_r) begin
            rsel_d = gnt1 ? PORT_AUX : PORT_CORE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rpend_q <= 1'b0;
            rsel_q  <= PORT_CORE;
        end else begin
            rpend_q <= rpend_d;
            rsel_q  <= rsel_d;
        end
    end

    // A read captured just before reset asserts is suppressed while rst_n is low.
    assign rvalid0 = rst_n && rpend_q && (rsel_q == PORT_CORE);
    assign rvalid1 = rst_n && rpend_q && (rsel_q == PORT_AUX);
    assign rdata0  = rvalid0 ? ram_rdata : '0;
    assign rdata1  = rvalid1 ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: table-driven vectors with a read-return
// scoreboard, plus hand sequences for reset, contention and idle behaviour.
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1;
    logic [3:0]  we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        ram_r;
    logic [3:0]  ram_w;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        req0, req1;
        logic [3:0]  we0, we1;
        logic [31:0] addr0, addr1, wdata0, wdata1;
        logic [1:0]  exp_gnt;   // {gnt1, gnt0}
        logic [31:0] exp_rd;    // data expected back if the winner reads
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } ret_t;

    ret_t sb[$];

    ram_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .ram_r     (ram_r),
        .ram_w     (ram_w),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: byte-strobed writes, registered 1-cycle read.
    logic [31:0] mem [0:63];
    logic [31:0] merged;
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        ram_rdata = '0;
    end
    always @(posedge clk) begin
        if (ram_r) ram_rdata <= mem[ram_addr[7:2]];
        if (ram_w != 4'h0) begin
            merged = mem[ram_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (ram_w[b]) merged[8*b +: 8] = ram_wdata[8*b +: 8];
            mem[ram_addr[7:2]] <= merged;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r0, input logic r1,
                                input logic [3:0] w0, input logic [3:0] w1,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [1:0] g, input logic [31:0] rd);
        vec_t v;
        v.req0 = r0; v.req1 = r1; v.we0 = w0; v.we1 = w1;
        v.addr0 = a0; v.addr1 = a1; v.wdata0 = d0; v.wdata1 = d1;
        v.exp_gnt = g; v.exp_rd = rd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        req0 = v.req0; req1 = v.req1; we0 = v.we0; we1 = v.we1;
        addr0 = v.addr0; addr1 = v.addr1; wdata0 = v.wdata0; wdata1 = v.wdata1;
    endtask

    // Compare this cycle's read-return against the oldest scoreboard entry.
    task automatic check_return();
        ret_t        e;
        logic [1:0]  exp_rv = 2'b00;
        logic [31:0] exp_d0 = '0;
        logic [31:0] exp_d1 = '0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.port) begin exp_rv = 2'b10; exp_d1 = e.data; end
            else        begin exp_rv = 2'b01; exp_d0 = e.data; end
        end
        check("rvalid", {62'd0, rvalid1, rvalid0}, {62'd0, exp_rv});
        check("rdata0", {32'd0, rdata0}, {32'd0, exp_d0});
        check("rdata1", {32'd0, rdata1}, {32'd0, exp_d1});
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input vec_t v, input bit expect_return);
        logic        exp_r = 1'b0;
        logic [3:0]  exp_w = 4'h0;
        logic [31:0] exp_a = '0;
        logic [31:0] exp_d = '0;
        ret_t        e;
        drive(v);
        @(negedge clk);
        check_return();
        check("gnt", {62'd0, gnt1, gnt0}, {62'd0, v.exp_gnt});
        if (v.exp_gnt == 2'b10) begin
            exp_w = v.we1; exp_a = v.addr1; exp_d = v.wdata1; exp_r = (v.we1 == 4'h0);
        end else if (v.exp_gnt == 2'b01) begin
            exp_w = v.we0; exp_a = v.addr0; exp_d = v.wdata0; exp_r = (v.we0 == 4'h0);
        end
        check("ram_rw", {59'd0, ram_r, ram_w}, {59'd0, exp_r, exp_w});
        check("ram_addr", {32'd0, ram_addr}, {32'd0, exp_a});
        check("ram_wdata", {32'd0, ram_wdata}, {32'd0, exp_d});
        if (exp_r && expect_return) begin
            e.port = v.exp_gnt[1];
            e.data = v.exp_rd;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, {62'd0, gnt1, gnt0}, 64'd0);
        check({tag, "_rvalid"}, {62'd0, rvalid1, rvalid0}, 64'd0);
        check({tag, "_rdata"}, {rdata1, rdata0}, 64'd0);
        check({tag, "_ram_ctl"}, {59'd0, ram_r, ram_w}, 64'd0);
        check({tag, "_ram_bus"}, {ram_addr, ram_wdata}, 64'd0);
    endtask

    localparam logic [31:0] D_A = 32'hDEADBEEF;
    localparam logic [31:0] D_B = 32'h1122AB44;

    vec_t vecs[10];
    vec_t idle_v, both_v, p1rd_v, busy_v;

    initial begin
        idle_v = mk(0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 32'h0);
        p1rd_v = mk(0, 1, 4'h0, 4'h0, 32'h0, 32'h20, 32'h0, 32'h0, 2'b10, D_B);
        busy_v = mk(1, 1, 4'hF, 4'hF, 32'h30, 32'h34, 32'h5A5A5A5A, 32'hA5A5A5A5, 2'b00, 32'h0);

        vecs[0] = mk(1, 0, 4'hF, 4'h0, 32'h10, 32'h0, D_A, 32'h0, 2'b01, 32'h0);
        vecs[1] = mk(1, 0, 4'h0, 4'h0, 32'h10, 32'h0, 32'h0, 32'h0, 2'b01, D_A);
        vecs[2] = idle_v;
        vecs[3] = mk(0, 1, 4'h0, 4'hF, 32'h0, 32'h20, 32'h0, 32'h11223344, 2'b10, 32'h0);
        vecs[4] = mk(0, 1, 4'h0, 4'h2, 32'h0, 32'h20, 32'h0, 32'h0000AB00, 2'b10, 32'h0);
        vecs[5] = p1rd_v;
        vecs[6] = mk(1, 0, 4'h0, 4'h0, 32'h10, 32'h0, 32'h0, 32'h0, 2'b01, D_A);
        vecs[7] = p1rd_v;
        vecs[8] = vecs[6];
        vecs[9] = idle_v;

        // Reset with both ports requesting: everything must stay quiet.
        rst_n = 1'b0;
        drive(busy_v);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all_zero("reset");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Writes, byte merge and back-to-back alternating reads.
        for (int i = 0; i < 10; i++) step(vecs[i], 1'b1);

        // Read granted on port 1, reset on the following edge: no return.
        drive(p1rd_v);
        @(negedge clk);
        check("midrd_gnt", {62'd0, gnt1, gnt0}, 64'd2);
        check_return();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(busy_v);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_all_zero("midrd_rst");
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;

        // Continuous contention from a cleared wait count: 0,0,0,0,1,0,0,0,0,1.
        for (int i = 0; i < 10; i++) begin
            both_v = mk(1, 1, 4'h0, 4'h0, 32'h10, 32'h20, 32'h0, 32'h0,
                        (i == 4 || i == 9) ? 2'b10 : 2'b01,
                        (i == 4 || i == 9) ? D_B : D_A);
            step(both_v, 1'b1);
        end

        // Two losses, ten idle cycles, then port 1 must win after two more losses.
        for (int i = 0; i < 2; i++) begin
            both_v = mk(1, 1, 4'h0, 4'h0, 32'h10, 32'h20, 32'h0, 32'h0, 2'b01, D_A);
            step(both_v, 1'b1);
        end
        for (int i = 0; i < 10; i++) step(idle_v, 1'b1);
        for (int i = 0; i < 3; i++) begin
            both_v = mk(1, 1, 4'h0, 4'h0, 32'h10, 32'h20, 32'h0, 32'h0,
                        (i == 2) ? 2'b10 : 2'b01, (i == 2) ? D_B : D_A);
            step(both_v, 1'b1);
        end
        step(idle_v, 1'b1);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
